am_lock_module: RTL and testbench

- Per-lane alignment-marker (AM) lock stage. Sits directly downstream of each lane's block-sync stage in the 100GbE PCS receive path.
- Consumes the 66-bit block stream and the block_lock flag for one PCS lane.
- Finds the periodic AM, identifies the PCS lane number carried in it, declares AM lock, and tags AM blocks for the downstream deskew/reorder logic.
- The RX toplevel instantiates one per lane (N_LANES=20).

---
 rtl/am_lock_module_pkg.sv | 55 +++++
 rtl/am_lock_module_if.sv | 37 +++
 rtl/am_lock_module_match.sv | 32 +++
 rtl/am_lock_module.sv | 162 ++++++++++++++++
 tb/tb_am_lock_module.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/am_lock_module_pkg.sv
`default_nettype none
// ============================================================================
// Module   : am_lock_module_pkg
// Brief    : Shared constants for the 100GbE PCS alignment-marker lock stage:
//            widths, AM encoding table, control sync header, FSM states.
//            Also intended for reuse by the TX AM inserter.
// Revision : 1.0 - initial release
// ============================================================================
package am_lock_module_pkg;

    localparam int NB_DATA       = 66;
    localparam int N_LANES       = 20;
    localparam int NB_LANE_ID    = $clog2(N_LANES);
    localparam int MAX_AM_PERIOD = 16384;
    localparam int NB_AM_PERIOD  = $clog2(MAX_AM_PERIOD);
    localparam int MAX_INV_AM    = 8;
    localparam int NB_INV_AM     = $clog2(MAX_INV_AM);

    // Sync header of a control block; AMs always carry it.
    localparam logic [1:0] CTRL_SH = 2'b10;

    // AM bytes M0,M1,M2 per PCS lane (IEEE 802.3 Table 82-2).
    // Packed with lane 19 in the top slice so AM_TABLE[i] is lane i.
    localparam logic [N_LANES-1:0][23:0] AM_TABLE = {
        24'hC0_F0_E5,   // lane 19
        24'h5F_66_2A,   // lane 18
        24'hAD_D6_B7,   // lane 17
        24'hC4_31_4C,   // lane 16
        24'h35_36_CD,   // lane 15
        24'h83_C7_CA,   // lane 14
        24'h1A_F8_BD,   // lane 13
        24'h5C_B9_B2,   // lane 12
        24'hB9_91_55,   // lane 11
        24'hFD_6C_99,   // lane 10
        24'h68_C9_FB,   // lane 9
        24'hA0_24_76,   // lane 8
        24'h7B_45_66,   // lane 7
        24'h9A_4A_26,   // lane 6
        24'hDD_14_C2,   // lane 5
        24'hF5_07_09,   // lane 4
        24'h4D_95_7B,   // lane 3
        24'h59_4B_E8,   // lane 2
        24'h9D_71_8E,   // lane 1
        24'hC1_68_21    // lane 0
    };

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        FIND_1ST  = 2'd1,
        COUNT_1   = 2'd2,
        AM_LOCKED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/am_lock_module_if.sv
`default_nettype none
// ============================================================================
// Module   : am_lock_module_if
// Brief    : Per-lane block stream, configuration and AM-lock status bundle.
//            master = block-sync side / register file, slave = AM lock stage.
// Revision : 1.0 - initial release
// ============================================================================
interface am_lock_module_if;
    import am_lock_module_pkg::*;

    // upstream block stream and configuration
    logic                    enable;
    logic                    valid;
    logic                    block_lock;
    logic [NB_DATA-1:0]      data;
    logic [NB_AM_PERIOD-1:0] rf_am_period;
    logic [NB_INV_AM-1:0]    rf_inv_am_thr;

    // downstream block stream and lock status
    logic [NB_DATA-1:0]      data_q;
    logic                    valid_q;
    logic                    am_flag;
    logic                    am_lock;
    logic [NB_LANE_ID-1:0]   lane_id;

    modport master (
        output enable, valid, block_lock, data, rf_am_period, rf_inv_am_thr,
        input  data_q, valid_q, am_flag, am_lock, lane_id
    );

    modport slave (
        input  enable, valid, block_lock, data, rf_am_period, rf_inv_am_thr,
        output data_q, valid_q, am_flag, am_lock, lane_id
    );

endinterface
`default_nettype wire

// File: rtl/am_lock_module_match.sv
`default_nettype none
// ============================================================================
// Module   : am_lock_module_match
// Brief    : Combinational AM detector. Compares a 66-bit block against the
//            20-entry AM table: control header, M0..M2 equal to the entry and
//            M4..M6 equal to its inverse. BIP3/BIP7 are don't-care.
// Revision : 1.0 - initial release
// ============================================================================
module am_lock_module_match
    import am_lock_module_pkg::*;
(
    input  logic [NB_DATA-1:0]    data,
    output logic                  match,
    output logic [NB_LANE_ID-1:0] lane
);

    // Table entries are unique, so at most one iteration can hit.
    always_comb begin
        match = 1'b0;
        lane  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if ((data[65:64] == CTRL_SH) &&
                (data[63:40] == AM_TABLE[i]) &&
                (data[31:8]  == ~AM_TABLE[i])) begin
                match = 1'b1;
                lane  = NB_LANE_ID'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/am_lock_module.sv
`default_nettype none
// ============================================================================
// Module   : am_lock_module
// Brief    : Per-lane alignment-marker lock. Finds the periodic AM, learns the
//            PCS lane number, declares lock after two same-lane AMs one period
//            apart, and flags expected AM slots for downstream deskew.
// Revision : 1.0 - initial release
// ============================================================================
module am_lock_module
    import am_lock_module_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    am_lock_module_if.slave bus
);

    logic                    match;
    logic [NB_LANE_ID-1:0]   match_lane;

    state_t                  state, state_nxt;
    logic [NB_AM_PERIOD-1:0] cnt, cnt_nxt, cnt_inc;
    logic [NB_AM_PERIOD-1:0] slot, slot_nxt, cfg_slot;
    logic [NB_INV_AM-1:0]    thr, thr_nxt;
    logic [NB_INV_AM-1:0]    inv, inv_nxt, inv_inc;
    logic [NB_LANE_ID-1:0]   cand, cand_nxt;
    logic [NB_LANE_ID-1:0]   lane_id, lane_id_nxt;
    logic                    am_lock, am_lock_nxt;
    logic                    am_flag_nxt;
    logic                    step, at_slot, same_lane;

    am_lock_module_match u_match (
        .data  (bus.data),
        .match (match),
        .lane  (match_lane)
    );

    // A period field of 0 wraps to 14'h3FFF, i.e. a 16384-block period.
    assign cfg_slot  = bus.rf_am_period - NB_AM_PERIOD'(1);
    assign step      = bus.valid && bus.enable;
    assign at_slot   = (cnt == slot);
    assign same_lane = match && (match_lane == cand);
    assign cnt_inc   = cnt + NB_AM_PERIOD'(1);
    assign inv_inc   = inv + NB_INV_AM'(1);

    // Next-state and counter logic; config is re-latched only while hunting
    // or at a period wrap, so mid-period register writes never shift a slot.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        slot_nxt    = slot;
        thr_nxt     = thr;
        inv_nxt     = inv;
        cand_nxt    = cand;
        lane_id_nxt = lane_id;
        am_lock_nxt = am_lock;
        am_flag_nxt = 1'b0;
        if (!bus.block_lock) begin
            state_nxt   = LOCK_INIT;
            cnt_nxt     = '0;
            inv_nxt     = '0;
            am_lock_nxt = 1'b0;
        end else if (step) begin
            case (state)
                LOCK_INIT: begin
                    cnt_nxt     = '0;
                    inv_nxt     = '0;
                    am_lock_nxt = 1'b0;
                    slot_nxt    = cfg_slot;
                    thr_nxt     = bus.rf_inv_am_thr;
                    state_nxt   = FIND_1ST;
                end
                FIND_1ST: begin
                    cnt_nxt  = '0;
                    slot_nxt = cfg_slot;
                    thr_nxt  = bus.rf_inv_am_thr;
                    if (match) begin
                        cand_nxt  = match_lane;
                        state_nxt = COUNT_1;
                    end
                end
                COUNT_1: begin
                    cnt_nxt = cnt_inc;
                    if (at_slot) begin
                        cnt_nxt  = '0;
                        slot_nxt = cfg_slot;
                        thr_nxt  = bus.rf_inv_am_thr;
                        if (same_lane) begin
                            // The confirming AM is itself tagged for deskew.
                            state_nxt   = AM_LOCKED;
                            am_lock_nxt = 1'b1;
                            inv_nxt     = '0;
                            lane_id_nxt = cand;
                            am_flag_nxt = 1'b1;
                        end else begin
                            state_nxt = FIND_1ST;
                        end
                    end
                end
                AM_LOCKED: begin
                    cnt_nxt = cnt_inc;
                    if (at_slot) begin
                        cnt_nxt     = '0;
                        slot_nxt    = cfg_slot;
                        thr_nxt     = bus.rf_inv_am_thr;
                        am_flag_nxt = 1'b1;
                        if (same_lane) begin
                            inv_nxt = '0;
                        end else if (inv_inc == thr) begin
                            state_nxt   = FIND_1ST;
                            am_lock_nxt = 1'b0;
                            inv_nxt     = '0;
                        end else begin
                            inv_nxt = inv_inc;
                        end
                    end
                end
                default: state_nxt = LOCK_INIT;
            endcase
        end
    end

    // FSM, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOCK_INIT;
            cnt         <= '0;
            slot        <= '0;
            thr         <= '0;
            inv         <= '0;
            cand        <= '0;
            lane_id     <= '0;
            am_lock     <= 1'b0;
            bus.am_flag <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            slot        <= slot_nxt;
            thr         <= thr_nxt;
            inv         <= inv_nxt;
            cand        <= cand_nxt;
            lane_id     <= lane_id_nxt;
            am_lock     <= am_lock_nxt;
            bus.am_flag <= am_flag_nxt;
        end
    end

    // One-cycle block pass-through, independent of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_q  <= '0;
            bus.valid_q <= 1'b0;
        end else begin
            bus.data_q  <= bus.data;
            bus.valid_q <= bus.valid;
        end
    end

    assign bus.am_lock = am_lock;
    assign bus.lane_id = lane_id;

endmodule
`default_nettype wire

// File: tb/tb_am_lock_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_am_lock_module
// Brief    : Directed self-checking bench for am_lock_module.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am_lock_module;

    logic clk = 1'b0;
    logic rst;

    am_lock_module_if bus ();

    am_lock_module dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Independent copy of the AM M0..M2 table, lane order.
    localparam logic [23:0] AM_TAB [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned seq      = 0;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // AM block for a lane with random BIP3/BIP7 bytes.
    function automatic logic [65:0] am_blk(input int lane);
        logic [23:0] m;
        logic [7:0]  b3, b7;
        m  = AM_TAB[lane];
        b3 = 8'($urandom);
        b7 = 8'($urandom);
        return {2'b10, m, b3, ~m, b7};
    endfunction

    // Apply one block, step past the clock edge, leave outputs settled.
    task automatic drive(input logic [65:0] d, input logic v, input logic en, input logic bl);
        bus.data       = d;
        bus.valid      = v;
        bus.enable     = en;
        bus.block_lock = bl;
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input logic [65:0] d);
        drive(d, 1'b1, 1'b1, 1'b1);
    endtask

    // n data blocks; am_flag must stay low on all of them.
    task automatic idles(input int n, input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            blk({2'b01, seq, ~seq});
            seq++;
            if (bus.am_flag !== 1'b0) bad++;
        end
        check(tag, 66'(bad), 66'd0);
    endtask

    task automatic expect_out(input string tag, input logic lock, input logic flag, input logic [4:0] lane);
        check({tag, "_lock"}, 66'(bus.am_lock), 66'(lock));
        check({tag, "_flag"}, 66'(bus.am_flag), 66'(flag));
        check({tag, "_lane"}, 66'(bus.lane_id), 66'(lane));
    endtask

    initial begin
        logic [65:0] bad_blk [4];
        int          bad;

        bad_blk[0] = {2'b01, 64'h0123_4567_89AB_CDEF};
        bad_blk[1] = am_blk(3);
        bad_blk[2] = am_blk(7) ^ (66'd1 << 16);
        bad_blk[3] = am_blk(7) ^ {2'b11, 64'd0};

        bus.rf_am_period  = 14'd0;
        bus.rf_inv_am_thr = 3'd4;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) drive({2'b10, 64'hDEADBEEF_CAFEF00D}, 1'b1, 1'b1, 1'b1);
        expect_out("rst", 1'b0, 1'b0, 5'd0);
        check("rst_valid", 66'(bus.valid_q), 66'd0);
        check("rst_data", bus.data_q, 66'd0);
        rst = 1'b0;

        // 16384-block period, lane 0
        idles(1, "t1_init");
        blk(am_blk(0));
        expect_out("t1_am1", 1'b0, 1'b0, 5'd0);
        idles(16383, "t1_gap");
        check("t1_prelock", 66'(bus.am_lock), 66'd0);
        blk(am_blk(0));
        expect_out("t1_am2", 1'b1, 1'b1, 5'd0);

        // unlock, then reconfigure to 256
        drive({2'b01, 64'd5}, 1'b1, 1'b1, 1'b0);
        expect_out("t1_drop", 1'b0, 1'b0, 5'd0);
        bus.rf_am_period = 14'd256;

        // lane 5 followed by lane 7 -> no lock; lane 7 pair -> lock
        idles(1, "t2_init");
        blk(am_blk(5));
        expect_out("t2_am5", 1'b0, 1'b0, 5'd0);
        idles(255, "t2_gap1");
        blk(am_blk(7));
        expect_out("t2_am7x", 1'b0, 1'b0, 5'd0);
        blk(am_blk(7));
        expect_out("t2_am7a", 1'b0, 1'b0, 5'd0);
        idles(255, "t2_gap2");
        blk(am_blk(7));
        expect_out("t2_am7b", 1'b1, 1'b1, 5'd7);

        // thr = 4: three bad then good keeps lock, four bad loses it
        for (int i = 0; i < 3; i++) begin
            idles(255, "t3_gap");
            blk(bad_blk[i]);
            expect_out("t3_bad3", 1'b1, 1'b1, 5'd7);
        end
        idles(255, "t3_gap");
        blk(am_blk(7));
        expect_out("t3_good", 1'b1, 1'b1, 5'd7);
        for (int i = 0; i < 4; i++) begin
            idles(255, "t3_gap");
            blk(bad_blk[i]);
            expect_out("t3_bad4", (i < 3), 1'b1, 5'd7);
        end

        // relock, then block_lock drop on an AM; relock after two AMs
        blk(am_blk(7));
        expect_out("t4_am1", 1'b0, 1'b0, 5'd7);
        idles(255, "t4_gap");
        blk(am_blk(7));
        expect_out("t4_lock", 1'b1, 1'b1, 5'd7);
        idles(255, "t4_gap");
        drive(am_blk(7), 1'b1, 1'b1, 1'b0);
        expect_out("t4_drop", 1'b0, 1'b0, 5'd7);
        idles(255, "t4_gap");
        blk(am_blk(7));
        expect_out("t4_re1", 1'b0, 1'b0, 5'd7);
        idles(255, "t4_gap");
        blk(am_blk(7));
        expect_out("t4_re2", 1'b1, 1'b1, 5'd7);

        // valid toggling and enable freeze shift the slot by counted blocks only
        idles(100, "t5_pre");
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            logic [65:0] d;
            logic        v, en;
            d = {2'b01, $urandom, $urandom};
            if (k < 20) begin
                v  = (k % 2 == 0);
                en = 1'b1;
            end else begin
                v  = 1'b1;
                en = 1'b0;
            end
            drive(d, v, en, 1'b1);
            check("t5_data", bus.data_q, d);
            check("t5_valid", 66'(bus.valid_q), 66'(v));
            if (bus.am_flag !== 1'b0) bad++;
        end
        check("t5_flag", 66'(bad), 66'd0);
        idles(145, "t5_post");
        blk(am_blk(7));
        expect_out("t5_slot", 1'b1, 1'b1, 5'd7);

        // stray AMs mid-period are ignored
        idles(100, "t6_gap");
        blk(am_blk(0));
        expect_out("t6_stray0", 1'b1, 1'b0, 5'd7);
        idles(154, "t6_gap");
        blk(am_blk(7));
        expect_out("t6_slot1", 1'b1, 1'b1, 5'd7);
        idles(50, "t6_gap");
        blk(am_blk(7));
        expect_out("t6_stray7", 1'b1, 1'b0, 5'd7);
        idles(204, "t6_gap");
        blk(am_blk(7));
        expect_out("t6_slot2", 1'b1, 1'b1, 5'd7);

        // thr = 1: a single bad AM drops lock
        drive({2'b01, 64'd9}, 1'b1, 1'b1, 1'b0);
        expect_out("t7_drop", 1'b0, 1'b0, 5'd7);
        bus.rf_inv_am_thr = 3'd1;
        idles(1, "t7_init");
        blk(am_blk(7));
        expect_out("t7_am1", 1'b0, 1'b0, 5'd7);
        idles(255, "t7_gap");
        blk(am_blk(7));
        expect_out("t7_lock", 1'b1, 1'b1, 5'd7);
        idles(255, "t7_gap");
        blk(am_blk(2));
        expect_out("t7_loss", 1'b0, 1'b1, 5'd7);

        // reset while locked
        blk(am_blk(7));
        idles(255, "t8_gap");
        blk(am_blk(7));
        expect_out("t8_lock", 1'b1, 1'b1, 5'd7);
        rst = 1'b1;
        blk(am_blk(7));
        rst = 1'b0;
        expect_out("t8_rst", 1'b0, 1'b0, 5'd0);
        idles(1, "t8_init");
        blk(am_blk(7));
        expect_out("t8_re1", 1'b0, 1'b0, 5'd0);
        idles(255, "t8_gap");
        blk(am_blk(7));
        expect_out("t8_re2", 1'b1, 1'b1, 5'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded cycle budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
